keypad_entry_buffer: RTL and testbench
======================================

Name: keypad_entry_buffer

Overview:
Clocked, parametrised successor of the button-to-code password entry stage. It synchronises and debounces NBTN digit keys plus delete and clear keys, encodes each accepted press as a key index, and shifts it into a DIGITS-deep entry register. It reports entry progress, completion and inactivity timeout to the lock-control FSM. Everything runs on one system clock; button signals are never used as clocks.

Parameters:
NBTN, 4, number of digit keys; key i encodes digit value i; 2..16.
DIGITS, 4, digits per complete entry; 1..8.
DW, 4, bits per stored digit; must be >= clog2(NBTN).
DEB_CYCLES, 20000, consecutive stable synchronised cycles required before an input change is accepted; >= 1.
TIMEOUT_CYCLES, 50000000, idle cycles in ENTRY before automatic clear; 0 disables the timeout.

Ports:
clk  in  1  system clock
rst  in  1  reset
btn  in  NBTN  raw digit keys, active-high, asynchronous to clk
btn_del  in  1  raw delete key
btn_clr  in  1  raw clear key
data  out  DIGITS*DW  entry; newest digit in bits [DW-1:0]
cnt  out  clog2(DIGITS+1)  digits currently held
full  out  1  high while cnt == DIGITS
done  out  1  one-cycle pulse when cnt becomes DIGITS
key_valid  out  1  one-cycle pulse per accepted digit press
key_code  out  DW  index of the last accepted digit, zero-extended
multi_err  out  1  one-cycle pulse when a press has more than one digit key set
timeout  out  1  one-cycle pulse on an inactivity clear

Behaviour:
- Reset rst: asynchronous, active-high. It clears the synchronisers, debounce counters, data, cnt, key_code and all pulses to 0 and forces state IDLE.
- Input path: every raw input passes through a 2-FF synchroniser. The synchronised vector {btn_clr, btn_del, btn} shares one debounce counter.
  - The counter restarts on any change in the vector.
  - When the vector has been stable for DEB_CYCLES cycles, it is copied into the debounced register.
- Press event: a cycle where the debounced vector goes from all-zero to non-zero. Releases and changes between non-zero values produce no event. From a raw 0->1 edge held stable, the event is acted on and pulses are visible DEB_CYCLES+3 cycles later.
- Event decode, in priority order:
  - clr set: clear.
  - del set: delete.
  - exactly one btn bit set: digit.
  - otherwise: multi_err pulse and no state change.
- States: IDLE (cnt=0), ENTRY (0<cnt<DIGITS), FULL (cnt=DIGITS).
- Digit event:
  - data <= (data << DW) | code; cnt+1; key_code <= code; key_valid pulses.
  - On the transition to cnt==DIGITS, done pulses in the same cycle as key_valid and the state moves to FULL.
- Digit event in FULL: starts a new entry. data <= code, cnt <= 1, state ENTRY. key_valid pulses; done does not pulse.
- Delete event: data <= data >> DW and cnt-1. Ignored when cnt==0. FULL goes to ENTRY, or to IDLE if DIGITS==1.
- Clear event: data <= 0, cnt <= 0, state IDLE. No pulse.
- Timeout:
  - The idle counter runs only in ENTRY and restarts on every press event.
  - On reaching TIMEOUT_CYCLES: data <= 0, cnt <= 0, state IDLE, timeout pulses for 1 cycle.
  - FULL never times out.
- full is combinational from the state. All other outputs are registered.
- Reset mid-debounce or mid-entry discards the pending press. The key must be released and pressed again to register.
- Bits of data above cnt*DW are always 0.

Test Plan:
- Reset, then press keys 1,3,0,2, each held 2*DEB_CYCLES and released -> data=16'h1302, cnt=4, full=1; done pulses once with the 4th key_valid.
- Glitch btn[2] high for DEB_CYCLES-1 cycles -> no key_valid, data unchanged. Hold it DEB_CYCLES+5 cycles -> key_valid DEB_CYCLES+3 cycles after the edge, key_code=2.
- With data=16'h1302 in FULL, press key 3 -> data=16'h0003, cnt=1, no done pulse.
- Enter 2,1, press del -> data=16'h0002, cnt=1. Press del twice more -> data=0, cnt=0, no underflow. Press clr after 3 digits -> data=0, IDLE.
- Press btn[0] and btn[1] together -> multi_err pulse, data and cnt unchanged. Press btn[1] and btn_clr together -> clear takes priority.
- TIMEOUT_CYCLES=1000: enter one digit, wait 1000 cycles -> timeout pulse, data=0, cnt=0. In FULL, wait 2000 cycles -> no timeout. Assert rst mid-press -> all outputs 0 immediately, no later key_valid.

Source files
------------

// File: rtl/keypad_entry_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : keypad_entry_buffer
//  Description : Synchronises and debounces a digit keypad plus delete/clear
//                keys, shifts accepted digits into a DIGITS-deep entry
//                register and reports progress, completion and idle timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
module keypad_entry_buffer #(
  parameter int NBTN           = 4,
  parameter int DIGITS         = 4,
  parameter int DW             = 4,
  parameter int DEB_CYCLES     = 20000,
  parameter int TIMEOUT_CYCLES = 50000000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NBTN-1:0]              btn,
  input  logic                         btn_del,
  input  logic                         btn_clr,
  output logic [DIGITS*DW-1:0]         data,
  output logic [$clog2(DIGITS+1)-1:0]  cnt,
  output logic                         full,
  output logic                         done,
  output logic                         key_valid,
  output logic [DW-1:0]                key_code,
  output logic                         multi_err,
  output logic                         timeout
);

  localparam int VW = NBTN + 2;
  localparam int CW = $clog2(DIGITS + 1);
  localparam int SW = $clog2(DEB_CYCLES + 1);
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int EW = DIGITS * DW;

  localparam logic [SW-1:0] C_DEB_MAX  = SW'(DEB_CYCLES);
  localparam logic [CW-1:0] C_CNT_FULL = CW'(DIGITS);
  localparam logic [TW-1:0] C_TO_LAST  = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ENTRY = 2'd1,
    FULL  = 2'd2
  } state_t;

  // Input path: raw keys as one vector {clr, del, digits}
  logic [VW-1:0] w_raw;
  logic [VW-1:0] sync1_q, sync2_q;
  logic [VW-1:0] cand_q, cand_d;
  logic [SW-1:0] stab_q, stab_d;
  logic [VW-1:0] deb_q, deb_d;
  logic          arm_q, arm_d;
  logic          w_press;

  // Entry state
  state_t        state_q, state_d;
  logic [EW-1:0] data_q, data_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] key_code_q, key_code_d;
  logic          key_valid_q, key_valid_d;
  logic          done_q, done_d;
  logic          multi_err_q, multi_err_d;
  logic          timeout_q, timeout_d;
  logic [TW-1:0] idle_q, idle_d;

  // Event decode
  logic [NBTN-1:0] w_btn;
  logic            w_onehot;
  logic [DW-1:0]   w_code;
  logic [EW-1:0]   w_code_ext;

  assign w_raw = {btn_clr, btn_del, btn};

  // Two-flop synchroniser for every raw key
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= w_raw;
      sync2_q <= sync1_q;
    end
  end

  // Shared debounce: count stable cycles of the synchronised vector, then
  // accept it. A press only counts once the keypad has been seen released
  // after reset (arm), so a key held through reset is ignored.
  always_comb begin
    cand_d  = cand_q;
    stab_d  = stab_q;
    deb_d   = deb_q;
    arm_d   = arm_q;
    if (sync2_q != cand_q) begin
      cand_d = sync2_q;
      stab_d = SW'(1);
    end else if (stab_q == C_DEB_MAX) begin
      deb_d = cand_q;
      if (cand_q == '0) begin
        arm_d = 1'b1;
      end
    end else begin
      stab_d = stab_q + SW'(1);
    end
    w_press = arm_q && (deb_q == '0) && (deb_d != '0);
  end

  // Debounce state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cand_q <= '0;
      stab_q <= '0;
      deb_q  <= '0;
      arm_q  <= 1'b0;
    end else begin
      cand_q <= cand_d;
      stab_q <= stab_d;
      deb_q  <= deb_d;
      arm_q  <= arm_d;
    end
  end

  // Encode the single set digit key as its index
  always_comb begin
    w_btn    = deb_d[NBTN-1:0];
    w_onehot = (w_btn != '0) && ((w_btn & (w_btn - NBTN'(1))) == '0);
    w_code   = '0;
    for (int i = 0; i < NBTN; i++) begin
      if (w_btn[i]) begin
        w_code = DW'(i);
      end
    end
    w_code_ext = EW'(w_code);
  end

  // Entry FSM next state: press events in priority clr > del > digit > error,
  // otherwise the idle timer in ENTRY
  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    cnt_d       = cnt_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    done_d      = 1'b0;
    multi_err_d = 1'b0;
    timeout_d   = 1'b0;
    idle_d      = '0;
    if (w_press) begin
      if (deb_d[NBTN+1]) begin
        data_d  = '0;
        cnt_d   = '0;
        state_d = IDLE;
      end else if (deb_d[NBTN]) begin
        if (cnt_q != '0) begin
          data_d  = data_q >> DW;
          cnt_d   = cnt_q - CW'(1);
          state_d = (cnt_q == CW'(1)) ? IDLE : ENTRY;
        end
      end else if (w_onehot) begin
        key_valid_d = 1'b1;
        key_code_d  = w_code;
        if (state_q == FULL) begin
          data_d  = w_code_ext;
          cnt_d   = CW'(1);
          state_d = (DIGITS == 1) ? FULL : ENTRY;
        end else begin
          data_d = (data_q << DW) | w_code_ext;
          cnt_d  = cnt_q + CW'(1);
          if (cnt_q == C_CNT_FULL - CW'(1)) begin
            state_d = FULL;
            done_d  = 1'b1;
          end else begin
            state_d = ENTRY;
          end
        end
      end else begin
        multi_err_d = 1'b1;
      end
    end else if ((state_q == ENTRY) && (TIMEOUT_CYCLES != 0)) begin
      if (idle_q == C_TO_LAST) begin
        data_d    = '0;
        cnt_d     = '0;
        state_d   = IDLE;
        timeout_d = 1'b1;
      end else begin
        idle_d = idle_q + TW'(1);
      end
    end
  end

  // Entry FSM registers and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      data_q      <= '0;
      cnt_q       <= '0;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      done_q      <= 1'b0;
      multi_err_q <= 1'b0;
      timeout_q   <= 1'b0;
      idle_q      <= '0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      cnt_q       <= cnt_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      done_q      <= done_d;
      multi_err_q <= multi_err_d;
      timeout_q   <= timeout_d;
      idle_q      <= idle_d;
    end
  end

  assign data      = data_q;
  assign cnt       = cnt_q;
  assign full      = (state_q == FULL);
  assign done      = done_q;
  assign key_valid = key_valid_q;
  assign key_code  = key_code_q;
  assign multi_err = multi_err_q;
  assign timeout   = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_keypad_entry_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_keypad_entry_buffer
//  Description : Self-checking bench for keypad_entry_buffer: table of key
//                presses with expected entries, directed corner sequences and
//                random presses against a queue-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_keypad_entry_buffer;

  localparam int NBTN = 4;
  localparam int DIGITS = 4;
  localparam int DW = 4;
  localparam int DEB = 8;
  localparam int TMO = 1000;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  btn;
  logic        btn_del, btn_clr;
  logic [15:0] data;
  logic [2:0]  cnt;
  logic        full, done, key_valid, multi_err, timeout;
  logic [3:0]  key_code;

  keypad_entry_buffer #(
    .NBTN(NBTN), .DIGITS(DIGITS), .DW(DW),
    .DEB_CYCLES(DEB), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst), .btn(btn), .btn_del(btn_del), .btn_clr(btn_clr),
    .data(data), .cnt(cnt), .full(full), .done(done), .key_valid(key_valid),
    .key_code(key_code), .multi_err(multi_err), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int kv_seen = 0, done_seen = 0, me_seen = 0, to_seen = 0;

  // Reference model: raw samples delayed two cycles, a window of the last
  // DEB+1 synchronised samples, and the entry kept as a queue of digits
  logic [5:0] p0, p1;
  logic [5:0] hist[$];
  logic [5:0] m_deb;
  bit         m_arm;
  int         q[$];
  int         m_idle;
  bit         m_kv, m_done, m_me, m_to;
  int         m_kc;

  task automatic model_reset();
    p0 = '0; p1 = '0; hist.delete(); m_deb = '0; m_arm = 0;
    q.delete(); m_idle = 0; m_kv = 0; m_done = 0; m_me = 0; m_to = 0; m_kc = 0;
  endtask

  function automatic logic [15:0] m_data();
    logic [15:0] d = '0;
    foreach (q[i]) d = (d << 4) | 16'(q[i]);
    return d;
  endfunction

  task automatic model_step(input logic [5:0] r);
    logic [5:0] s;
    bit all_eq, ev;
    int code;
    s = p1; p1 = p0; p0 = r;
    hist.push_back(s);
    if (hist.size() > DEB + 1) void'(hist.pop_front());
    m_kv = 0; m_done = 0; m_me = 0; m_to = 0;
    ev = 0;
    if (hist.size() == DEB + 1) begin
      all_eq = 1;
      foreach (hist[i]) if (hist[i] != s) all_eq = 0;
      if (all_eq) begin
        if (m_arm && m_deb == 0 && s != 0) ev = 1;
        if (s == 0) m_arm = 1;
        m_deb = s;
      end
    end
    if (ev) begin
      m_idle = 0;
      if (s[5]) q.delete();
      else if (s[4]) begin
        if (q.size() > 0) void'(q.pop_back());
      end else if ($countones(s[3:0]) == 1) begin
        code = 0;
        for (int i = 0; i < 4; i++) if (s[i]) code = i;
        if (q.size() == DIGITS) begin
          q.delete();
          q.push_back(code);
        end else begin
          q.push_back(code);
          if (q.size() == DIGITS) m_done = 1;
        end
        m_kv = 1; m_kc = code;
      end else m_me = 1;
    end else if (q.size() > 0 && q.size() < DIGITS) begin
      m_idle++;
      if (m_idle == TMO) begin
        q.delete(); m_to = 1; m_idle = 0;
      end
    end else m_idle = 0;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: advance the model on the active edge, compare just after it
  task automatic tick();
    logic [27:0] act, exp;
    @(posedge clk);
    cyc++;
    if (rst) model_reset();
    else model_step({btn_clr, btn_del, btn});
    #1;
    act = {data, cnt, full, done, key_valid, key_code, multi_err, timeout};
    exp = {m_data(), 3'(q.size()), q.size() == DIGITS, m_done, m_kv, 4'(m_kc), m_me, m_to};
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL model_cycle: actual %07h, required %07h (cycle %0d)", act, exp, cyc);
    end
    if (key_valid) kv_seen++;
    if (done) done_seen++;
    if (multi_err) me_seen++;
    if (timeout) to_seen++;
  endtask

  task automatic drive(input logic [5:0] k);
    {btn_clr, btn_del, btn} = k;
  endtask

  task automatic press(input logic [5:0] k, input int hold, input int gap);
    drive(k);
    repeat (hold) tick();
    drive(6'b0);
    repeat (gap) tick();
  endtask

  typedef struct {
    logic [5:0]  keys;
    logic [15:0] exp_data;
    int          exp_cnt;
    logic        exp_full;
  } vec_t;

  vec_t tbl[16];

  initial begin
    int lat, n, kv0, d0, k0, me0, to0, a, b, kind;
    logic [5:0] k;

    tbl[0]  = '{6'b000010, 16'h0001, 1, 1'b0};
    tbl[1]  = '{6'b001000, 16'h0013, 2, 1'b0};
    tbl[2]  = '{6'b000001, 16'h0130, 3, 1'b0};
    tbl[3]  = '{6'b000100, 16'h1302, 4, 1'b1};
    tbl[4]  = '{6'b001000, 16'h0003, 1, 1'b0};
    tbl[5]  = '{6'b100000, 16'h0000, 0, 1'b0};
    tbl[6]  = '{6'b000100, 16'h0002, 1, 1'b0};
    tbl[7]  = '{6'b000010, 16'h0021, 2, 1'b0};
    tbl[8]  = '{6'b010000, 16'h0002, 1, 1'b0};
    tbl[9]  = '{6'b010000, 16'h0000, 0, 1'b0};
    tbl[10] = '{6'b010000, 16'h0000, 0, 1'b0};
    tbl[11] = '{6'b000010, 16'h0001, 1, 1'b0};
    tbl[12] = '{6'b000011, 16'h0001, 1, 1'b0};
    tbl[13] = '{6'b000100, 16'h0012, 2, 1'b0};
    tbl[14] = '{6'b001000, 16'h0123, 3, 1'b0};
    tbl[15] = '{6'b100010, 16'h0000, 0, 1'b0};

    rst = 1'b1;
    drive(6'b0);
    model_reset();
    repeat (3) tick();
    chk("reset_data", data, 0);
    chk("reset_cnt", cnt, 0);
    chk("reset_full", full, 0);
    chk("reset_key_code", key_code, 0);
    rst = 1'b0;
    repeat (2 * DEB) tick();

    // Table of presses with expected entry after each release
    done_seen = 0; me_seen = 0;
    for (int i = 0; i < 16; i++) begin
      press(tbl[i].keys, 2 * DEB, 2 * DEB);
      chk($sformatf("tbl%0d_data", i), data, tbl[i].exp_data);
      chk($sformatf("tbl%0d_cnt", i), cnt, tbl[i].exp_cnt);
      chk($sformatf("tbl%0d_full", i), full, tbl[i].exp_full);
    end
    chk("tbl_done_count", done_seen, 1);
    chk("tbl_multi_err_count", me_seen, 1);

    // Short glitch is rejected
    press(6'b000010, 2 * DEB, 2 * DEB);
    kv0 = kv_seen;
    press(6'b000100, DEB - 1, 3 * DEB);
    chk("glitch_no_key", kv_seen - kv0, 0);
    chk("glitch_data", data, 16'h0001);

    // Latency from raw edge to key_valid
    drive(6'b000100);
    lat = -1;
    for (int i = 1; i <= DEB + 5; i++) begin
      tick();
      if (key_valid && lat < 0) begin
        lat = i;
        k0 = key_code;
      end
    end
    drive(6'b0);
    repeat (2 * DEB) tick();
    chk("press_latency", lat, DEB + 3);
    chk("press_key_code", k0, 2);

    // Inactivity timeout after one digit
    press(6'b100000, 2 * DEB, 2 * DEB);
    drive(6'b001000);
    n = 0;
    while (!key_valid && n < 4 * DEB) begin
      tick();
      n++;
    end
    chk("timeout_entry_key", key_valid, 1);
    drive(6'b0);
    n = 0;
    to0 = to_seen;
    while (to_seen == to0 && n < 2 * TMO) begin
      tick();
      n++;
    end
    chk("timeout_delay", n, TMO);
    chk("timeout_data", data, 0);
    chk("timeout_cnt", cnt, 0);

    // FULL never times out
    for (int i = 0; i < 4; i++) press(6'(1 << i), 2 * DEB, 2 * DEB);
    to0 = to_seen;
    repeat (2 * TMO) tick();
    chk("full_no_timeout", to_seen - to0, 0);
    chk("full_cnt_kept", cnt, 4);
    chk("full_data_kept", data, 16'h0123);

    // Reset in the middle of a press discards it
    drive(6'b000010);
    repeat (DEB / 2) tick();
    rst = 1'b1;
    #1;
    chk("rst_async_data", data, 0);
    chk("rst_async_cnt", cnt, 0);
    chk("rst_async_full", full, 0);
    chk("rst_async_pulses", {done, key_valid, multi_err, timeout}, 0);
    repeat (3) tick();
    rst = 1'b0;
    kv0 = kv_seen;
    repeat (3 * DEB) tick();
    drive(6'b0);
    repeat (3 * DEB) tick();
    chk("rst_press_discarded", kv_seen - kv0, 0);
    press(6'b000100, 2 * DEB, 2 * DEB);
    chk("rst_next_press", data, 2);

    // Random presses against the model
    kv0 = kv_seen; d0 = done_seen; me0 = me_seen; to0 = to_seen;
    for (int it = 0; it < 250; it++) begin
      kind = $urandom_range(0, 19);
      a = $urandom_range(0, 3);
      if (kind == 0) k = 6'b100000 | 6'($urandom_range(0, 15));
      else if (kind <= 2) k = 6'b010000;
      else if (kind == 3) begin
        b = (a + 1 + $urandom_range(0, 2)) % 4;
        k = 6'((1 << a) | (1 << b));
      end else k = 6'(1 << a);
      press(k, $urandom_range(1, 2 * DEB + 4),
            ($urandom_range(0, 24) == 0) ? TMO + 50 : $urandom_range(1, 2 * DEB + 4));
    end
    repeat (3 * DEB) tick();
    chk("random_saw_keys", kv_seen - kv0 > 20, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
